// File: rtl/alu_iter.sv
// alu_iter: small ALU with single-cycle ADD/SUB/NAND/ROTL/NOP and
// iterative shift-add MULT and restoring DIV/MOD (one bit per cycle).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; single-cycle ops complete here
// ITER   | MULT/DIV/MOD running, one iteration per clock, busy high
// FINISH | result just written, done high, back to IDLE next edge
//
// OP_BITS is expected to be at least 3; codes above 7 decode to NOP.
module alu_iter #(
  parameter int NUM_BITS = 16,
  parameter int OP_BITS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_BITS-1:0]  operator,
  input  logic [NUM_BITS-1:0] op1,
  input  logic [NUM_BITS-1:0] op2,
  output logic [NUM_BITS-1:0] op3,
  output logic                busy,
  output logic                done,
  output logic [3:0]          flags
);

  localparam int CW = $clog2(NUM_BITS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ITER   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_ROTL = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          opc_q, opc_d;
  // hi/lo: product halves for MULT, remainder/quotient for DIV/MOD
  logic [NUM_BITS-1:0] hi_q, hi_d;
  logic [NUM_BITS-1:0] lo_q, lo_d;
  // b: multiplicand for MULT, divisor for DIV/MOD
  logic [NUM_BITS-1:0] b_q, b_d;
  logic [NUM_BITS-1:0] op3_q, op3_d;
  logic [3:0]          flags_q, flags_d;
  logic                done_q, done_d;

  logic [2:0]          op_in;
  logic                op_iter;
  logic [NUM_BITS-1:0] sc_res;
  logic [3:0]          sc_flags;
  logic [NUM_BITS-1:0] step_hi, step_lo;

  // Decode the incoming opcode; anything outside 0..7 is NOP.
  always_comb begin
    op_in = (operator > OP_BITS'(7)) ? OP_NOP : operator[2:0];
    op_iter = (op_in == OP_MULT) ||
              (((op_in == OP_DIV) || (op_in == OP_MOD)) && (op2 != '0));
  end

  // Single-cycle datapath, including the divide-by-zero shortcut.
  always_comb begin
    logic [NUM_BITS:0] sum;
    logic [NUM_BITS:0] dif;
    logic              dz, ovf, cy;
    sum    = {1'b0, op1} + {1'b0, op2};
    dif    = {1'b0, op1} - {1'b0, op2};
    sc_res = '0;
    dz     = 1'b0;
    ovf    = 1'b0;
    cy     = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_res = sum[NUM_BITS-1:0];
        cy     = sum[NUM_BITS];
        ovf    = (op1[NUM_BITS-1] == op2[NUM_BITS-1]) &&
                 (sum[NUM_BITS-1] != op1[NUM_BITS-1]);
      end
      OP_SUB: begin
        sc_res = dif[NUM_BITS-1:0];
        cy     = dif[NUM_BITS];
        ovf    = (op1[NUM_BITS-1] != op2[NUM_BITS-1]) &&
                 (dif[NUM_BITS-1] != op1[NUM_BITS-1]);
      end
      OP_NAND: sc_res = ~(op1 & op2);
      OP_ROTL: begin
        sc_res = {op1[NUM_BITS-2:0], op1[NUM_BITS-1]};
        cy     = op1[NUM_BITS-1];
      end
      OP_DIV: begin
        sc_res = '1;
        dz     = 1'b1;
      end
      OP_MOD: begin
        sc_res = op1;
        dz     = 1'b1;
      end
      default: sc_res = '0;
    endcase
    sc_flags = {dz, ovf, cy, (sc_res == '0)};
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    logic [NUM_BITS:0]   msum;
    logic [NUM_BITS:0]   rem_sh;
    logic [NUM_BITS-1:0] rdif;
    logic                borrow;
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {hi_q, lo_q[NUM_BITS-1]};
    rdif   = rem_sh[NUM_BITS-1:0] - b_q;
    borrow = (rem_sh < {1'b0, b_q});
    if (opc_q == OP_MULT) begin
      step_hi = msum[NUM_BITS:1];
      step_lo = {msum[0], lo_q[NUM_BITS-1:1]};
    end else if (borrow) begin
      step_hi = rem_sh[NUM_BITS-1:0];
      step_lo = {lo_q[NUM_BITS-2:0], 1'b0};
    end else begin
      step_hi = rdif;
      step_lo = {lo_q[NUM_BITS-2:0], 1'b1};
    end
  end

  // FSM next-state, operand capture and result write-back.
  always_comb begin
    logic [NUM_BITS-1:0] fres;
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    op3_d   = op3_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    fres    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opc_d = op_in;
          if (op_iter) begin
            state_d = S_ITER;
            cnt_d   = CW'(NUM_BITS);
            hi_d    = '0;
            lo_d    = op1;
            b_d     = op2;
          end else begin
            op3_d   = sc_res;
            flags_d = sc_flags;
            done_d  = 1'b1;
          end
        end
      end
      S_ITER: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last iteration: write the result straight from the step logic.
          fres    = (opc_q == OP_MOD) ? step_hi : step_lo;
          op3_d   = fres;
          flags_d = {1'b0, (opc_q == OP_MULT) && (step_hi != '0), 1'b0,
                     (fres == '0)};
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opc_q   <= OP_NOP;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op3_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op3_q   <= op3_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign op3   = op3_q;
  assign flags = flags_q;
  assign done  = done_q;
  assign busy  = (state_q == S_ITER);

endmodule

// File: tb/tb_alu_iter.sv
// Randomised and directed bench for alu_iter at NUM_BITS=16.
module tb_alu_iter;

  localparam int N = 16;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] MULT = 3'd2;
  localparam logic [2:0] NAND = 3'd3;
  localparam logic [2:0] DIV  = 3'd4;
  localparam logic [2:0] MOD  = 3'd5;
  localparam logic [2:0] ROTL = 3'd6;
  localparam logic [2:0] NOP  = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    operator;
  logic [N-1:0]  op1, op2, op3;
  logic          busy, done;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;

  alu_iter #(.NUM_BITS(N), .OP_BITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .operator(operator),
    .op1(op1), .op2(op2), .op3(op3), .busy(busy), .done(done),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode's definition.
  function automatic void model(input logic [2:0] op, input int a, input int b,
                                output int res, output logic [3:0] flg,
                                output int lat);
    longint p;
    int sa, sb, ss;
    bit dz, ovf, cy;
    dz = 0; ovf = 0; cy = 0; lat = 0; res = 0;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (op)
      ADD: begin
        res = (a + b) % 65536; cy = (a + b) >= 65536;
        ss = sa + sb; ovf = (ss > 32767) || (ss < -32768);
      end
      SUB: begin
        res = (a - b + 65536) % 65536; cy = a < b;
        ss = sa - sb; ovf = (ss > 32767) || (ss < -32768);
      end
      MULT: begin
        p = longint'(a) * longint'(b);
        res = int'(p % 65536); ovf = (p / 65536) != 0; lat = 16;
      end
      NAND: res = 65535 - (a & b);
      DIV: begin
        if (b == 0) begin res = 65535; dz = 1; end
        else begin res = a / b; lat = 16; end
      end
      MOD: begin
        if (b == 0) begin res = a; dz = 1; end
        else begin res = a % b; lat = 16; end
      end
      ROTL: begin res = (a * 2) % 65536 + a / 32768; cy = a >= 32768; end
      default: res = 0;
    endcase
    flg = {dz, ovf, cy, res == 0};
  endfunction

  // Issue one op, follow it to done and check timing, result and flags.
  task automatic run_op(input logic [2:0] op, input int a, input int b,
                        input bit ign_start);
    int res, lat, elat, bcnt;
    logic [3:0] flg;
    model(op, a, b, res, flg, elat);
    operator = op; op1 = N'(a); op2 = N'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operator = 3'($urandom); op1 = N'($urandom); op2 = N'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      start = (ign_start && lat == 4);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, elat);
    chk("busy_cycles", bcnt, elat);
    chk("busy_at_done", busy, 0);
    chk("op3", op3, res);
    chk("flags", flags, flg);
    @(posedge clk); #1;
    chk("done_drop", done, 0);
    chk("op3_hold", op3, res);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int res, lat, dcnt;
    logic [3:0] flg;
    logic [2:0] sc_ops [5];
    logic [2:0] op;
    int a, b;
    sc_ops[0] = ADD; sc_ops[1] = SUB; sc_ops[2] = NAND;
    sc_ops[3] = ROTL; sc_ops[4] = NOP;

    rst = 1'b1; start = 1'b0; operator = ADD; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op3", op3, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(ADD, 16'hFFFF, 16'h0001, 0);
    chk("add_wrap_op3", op3, 16'h0000);
    chk("add_wrap_flags", flags, 4'b0011);
    run_op(SUB, 16'h8000, 16'h0001, 0);
    chk("sub_ovf_op3", op3, 16'h7FFF);
    chk("sub_ovf_flags", flags, 4'b0100);
    run_op(ROTL, 16'h8001, 0, 0);
    chk("rotl_op3", op3, 16'h0003);
    chk("rotl_flags", flags, 4'b0010);
    run_op(MULT, 16'h0100, 16'h0100, 1);
    chk("mult_op3", op3, 16'h0000);
    chk("mult_flags", flags, 4'b0101);
    run_op(DIV, 1000, 7, 0);
    chk("div_op3", op3, 142);
    run_op(MOD, 1000, 7, 0);
    chk("mod_op3", op3, 6);
    run_op(DIV, 16'h1234, 0, 0);
    chk("divz_op3", op3, 16'hFFFF);
    chk("divz_flags", flags, 4'b1000);
    run_op(MOD, 16'h1234, 0, 0);

    // Reset in the middle of a divide.
    operator = DIV; op1 = 16'd1000; op2 = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_op3", op3, 0);
    chk("abort_flags", flags, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);
    run_op(ADD, 2, 3, 0);
    chk("post_rst_add", op3, 5);

    // Back-to-back single-cycle ops, one result per clock.
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = sc_ops[$urandom_range(0, 4)];
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      model(op, a, b, res, flg, lat);
      operator = op; op1 = N'(a); op2 = N'(b);
      @(posedge clk); #1;
      chk("b2b_done", done, 1);
      chk("b2b_op3", op3, res);
      chk("b2b_flags", flags, flg);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", done, 0);

    // Random mix of every opcode.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = int'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = int'($urandom_range(1, 15));
        default: b = int'($urandom_range(0, 65535));
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
